// File: rtl/sprite_pkg.sv
// -----------------------------------------------------------------------------
// sprite_pkg
// Shared definitions for the sprite blitter: the blitter state encoding,
// the palette index width, and the default framebuffer geometry and
// transparency key.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sprite_pkg;

  localparam int PALETTE_IDX_W = 4;

  localparam int DEF_FB_W = 320;
  localparam int DEF_FB_H = 240;

  localparam logic [PALETTE_IDX_W-1:0] DEF_TRANSP_IDX = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage

// File: rtl/duck_sprite_blitter.sv
// -----------------------------------------------------------------------------
// duck_sprite_blitter
// Copies one palette-indexed sprite from the sprite ROM into the indexed
// framebuffer at a requested screen position. The transparency key is not
// written and pixels falling outside the screen are clipped. One pixel per
// cycle with a fixed latency.
//
// Ports:
//   vga_clk      sole clock (posedge)
//   reset        asynchronous, active-high
//   start        draw request, sampled only while idle
//   pos_x/pos_y  sprite top-left position, latched on accept
//   rom_base     first ROM word of the sprite, latched on accept
//   busy         high from accept through the final write
//   done         one-cycle pulse after the final write
//   rom_address  sprite ROM read address (ROM registers it, data next cycle)
//   rom_q        sprite ROM data
//   fb_we/fb_addr/fb_data  framebuffer write port
// -----------------------------------------------------------------------------
module duck_sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 68,
  parameter int SPRITE_H = 64,
  parameter int FB_W     = DEF_FB_W,
  parameter int FB_H     = DEF_FB_H,
  parameter int ROM_AW   = 13,
  parameter int FB_AW    = 17,
  parameter logic [PALETTE_IDX_W-1:0] TRANSP_IDX = DEF_TRANSP_IDX
) (
  input  logic                     vga_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [9:0]               pos_x,
  input  logic [9:0]               pos_y,
  input  logic [ROM_AW-1:0]        rom_base,
  output logic                     busy,
  output logic                     done,
  output logic [ROM_AW-1:0]        rom_address,
  input  logic [PALETTE_IDX_W-1:0] rom_q,
  output logic                     fb_we,
  output logic [FB_AW-1:0]         fb_addr,
  output logic [PALETTE_IDX_W-1:0] fb_data
);

  localparam int NPIX  = SPRITE_W * SPRITE_H;
  localparam int SX_W  = $clog2(SPRITE_W + 1);
  localparam int SY_W  = $clog2(SPRITE_H + 1);
  localparam int PIX_W = $clog2(NPIX + 1);

  blit_state_t       r_state;
  blit_state_t       w_next;
  logic              w_accept;
  logic              w_last;
  logic              w_sx_wrap;

  logic [SX_W-1:0]   r_sx;
  logic [SY_W-1:0]   r_sy;
  logic [PIX_W-1:0]  r_pix;

  logic [9:0]        r_pos_x;
  logic [9:0]        r_pos_y;
  logic [ROM_AW-1:0] r_base;

  // 11-bit screen coordinates so pos + offset can never wrap
  logic [10:0]       w_x;
  logic [10:0]       w_y;
  logic              w_inb;
  logic [FB_AW-1:0]  w_addr;

  logic              r_vld_p1;
  logic              r_inb_p1;
  logic [FB_AW-1:0]  r_addr_p1;

  assign w_last    = (r_pix == PIX_W'(NPIX - 1));
  assign w_sx_wrap = (r_sx == SX_W'(SPRITE_W - 1));

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: begin
        busy   = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request parameters only matter while a draw is in flight, so they need no reset
  always_ff @(posedge vga_clk) begin
    if (w_accept) begin
      r_pos_x <= pos_x;
      r_pos_y <= pos_y;
      r_base  <= rom_base;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_pix <= '0;
    end else if (w_accept) begin
      r_sx  <= '0;
      r_sy  <= '0;
      r_pix <= '0;
    end else if (r_state == RUN) begin
      r_pix <= r_pix + 1'b1;
      if (w_sx_wrap) begin
        r_sx <= '0;
        r_sy <= r_sy + 1'b1;
      end else begin
        r_sx <= r_sx + 1'b1;
      end
    end
  end

  assign w_x    = {1'b0, r_pos_x} + 11'(r_sx);
  assign w_y    = {1'b0, r_pos_y} + 11'(r_sy);
  assign w_inb  = (int'(w_x) < FB_W) && (int'(w_y) < FB_H);
  assign w_addr = FB_AW'(int'(w_y) * FB_W + int'(w_x));

  // ---- stage p1: clip flag and framebuffer address, aligned with ROM data ----
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_inb_p1  <= 1'b0;
      r_addr_p1 <= '0;
    end else if (r_state == RUN) begin
      r_vld_p1  <= 1'b1;
      r_inb_p1  <= w_inb;
      r_addr_p1 <= w_addr;
    end else begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign rom_address = (r_state == RUN) ? r_base + ROM_AW'(r_pix) : '0;

  assign fb_we   = r_vld_p1 && r_inb_p1 && (rom_q != TRANSP_IDX);
  assign fb_addr = r_addr_p1;
  // Held at zero outside a draw so the port is quiet after reset
  assign fb_data = r_vld_p1 ? rom_q : '0;

endmodule

// File: tb/tb_duck_sprite_blitter.sv
module tb_duck_sprite_blitter;

  localparam int SW    = 4;
  localparam int SH    = 2;
  localparam int N     = SW * SH;
  localparam int FBW   = 320;
  localparam int FBH   = 240;
  localparam int ROMSZ = 8192;

  logic        vga_clk  = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [9:0]  pos_x    = '0;
  logic [9:0]  pos_y    = '0;
  logic [12:0] rom_base = '0;
  logic        busy;
  logic        done;
  logic [12:0] rom_address;
  logic [3:0]  rom_q;
  logic        fb_we;
  logic [16:0] fb_addr;
  logic [3:0]  fb_data;

  logic [3:0]  rom [0:ROMSZ-1];

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 vga_clk = ~vga_clk;

  // Synchronous sprite ROM: address registered on the clock edge
  always @(posedge vga_clk) rom_q <= rom[rom_address];

  duck_sprite_blitter #(
    .SPRITE_W(SW),
    .SPRITE_H(SH)
  ) dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .start      (start),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .rom_base   (rom_base),
    .busy       (busy),
    .done       (done),
    .rom_address(rom_address),
    .rom_q      (rom_q),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every sprite pixel in raster order, kept if on-screen and not the key
  function automatic void push_expected(input int px, input int py, input int base);
    for (int k = 0; k < N; k++) begin
      int x, y, d;
      x = px + (k % SW);
      y = py + (k / SW);
      d = int'(rom[(base + k) % ROMSZ]);
      if (x < FBW && y < FBH && d != 0)
        exp_q.push_back('{addr: y * FBW + x, data: d});
    end
  endfunction

  // Scoreboard monitor: every write must match the next expected write
  always @(negedge vga_clk) begin
    wr_t e;
    if (fb_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=%0d, expected no write (t=%0t)",
                 fb_addr, fb_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (int'(fb_addr) != e.addr || int'(fb_data) != e.data) begin
          fails++;
          $display("FAIL write: got addr=%0d data=%0d, expected addr=%0d data=%0d (t=%0t)",
                   fb_addr, fb_data, e.addr, e.data, $time);
        end
      end
    end
  end

  // One draw: accept at the first posedge, then check busy/done cycle by cycle
  task automatic draw(input int px, input int py, input int base, input bit hold);
    pos_x    = 10'(px);
    pos_y    = 10'(py);
    rom_base = 13'(base);
    start    = 1'b1;
    push_expected(px, py, base);
    @(posedge vga_clk);
    #1;
    if (!hold) start = 1'b0;
    for (int c = 1; c <= N + 2; c++) begin
      @(negedge vga_clk);
      chk("busy", int'(busy), int'(c <= N + 1));
      chk("done", int'(done), int'(c == N + 2));
      if (c == N + 2) chk("pending_writes", exp_q.size(), 0);
      if (hold) pos_x = 10'($urandom_range(0, 1023));
    end
    @(negedge vga_clk);
    chk("idle_busy", int'(busy), 0);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++) rom[i] = 4'(i + 1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < ROMSZ; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));

    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fb_we", int'(fb_we), 0);
    chk("rst_rom_address", int'(rom_address), 0);
    chk("rst_fb_addr", int'(fb_addr), 0);
    chk("rst_fb_data", int'(fb_data), 0);
    @(negedge vga_clk);
    reset = 1'b0;
    @(negedge vga_clk);

    // Plain ramp sprite, fully on screen
    load_ramp();
    draw(10, 20, 0, 1'b0);

    // Transparent pixels 2 and 5
    rom[2] = 4'h0;
    rom[5] = 4'h0;
    draw(10, 20, 0, 1'b0);

    // Bottom-right corner clipping
    load_ramp();
    draw(318, 239, 0, 1'b0);

    // Fully off screen
    draw(400, 300, 0, 1'b0);

    // ROM address wrap
    draw(100, 100, ROMSZ - 3, 1'b0);

    // start held across the draw, pos_x changing while busy; back-to-back second draw
    draw(50, 60, 0, 1'b1);
    draw(70, 80, 16, 1'b0);

    // Reset in the middle of RUN at pixel 3
    load_ramp();
    pos_x    = 10'd10;
    pos_y    = 10'd20;
    rom_base = 13'd0;
    start    = 1'b1;
    push_expected(10, 20, 0);
    @(posedge vga_clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge vga_clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_fb_we", int'(fb_we), 0);
    chk("mid_rst_done", int'(done), 0);
    repeat (3) begin
      @(negedge vga_clk);
      chk("in_rst_busy", int'(busy), 0);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge vga_clk);
      chk("post_rst_idle_busy", int'(busy), 0);
    end
    draw(10, 20, 0, 1'b0);

    // Randomized draws, biased toward the screen edges
    for (int t = 0; t < 20; t++) begin
      int px, py;
      px = ($urandom_range(0, 1) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
      py = ($urandom_range(0, 1) == 0) ? int'($urandom_range(230, 250)) : int'($urandom_range(0, 239));
      draw(px, py, int'($urandom_range(0, ROMSZ - 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/duck_sprite_blitter.md
Name: duck_sprite_blitter

Overview:
- Writer-side counterpart to the sprite ROM readers: copies one palette-indexed sprite from a sprite ROM into the indexed framebuffer RAM at a requested screen position.
- Applies a transparency key and screen-edge clipping.
- Sits between the game logic, which issues draw requests, and the framebuffer write port.
- The VGA scan-out path reads the framebuffer; each write is a 4-bit palette index.

Parameters:
- SPRITE_W, 68, sprite width in pixels.
- SPRITE_H, 64, sprite height in pixels.
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in pixels.
- ROM_AW, 13, sprite ROM address width.
- FB_AW, 17, framebuffer address width.
- TRANSP_IDX, 4'h0, palette index that is not written.

Ports:
- vga_clk, in, 1, sole clock; all state updates on posedge.
- reset, in, 1, asynchronous, active-high.
- start, in, 1, draw request; sampled only in IDLE.
- pos_x, in, 10, sprite top-left X in framebuffer pixels; latched on accept.
- pos_y, in, 10, sprite top-left Y; latched on accept.
- rom_base, in, ROM_AW, first ROM word of the sprite (animation frame select); latched on accept.
- busy, out, 1, high from accept through the final write.
- done, out, 1, one-cycle pulse after the final write.
- rom_address, out, ROM_AW, sprite ROM read address.
- rom_q, in, 4, sprite ROM data; valid one cycle after its address was presented (ROM registers its address on vga_clk).
- fb_we, out, 1, framebuffer write enable.
- fb_addr, out, FB_AW, framebuffer write address.
- fb_data, out, 4, palette index to write.

Behaviour:
- Reset (asynchronous, any state): state IDLE; counters 0; stage valid 0; busy=0, done=0, fb_we=0, rom_address=0, fb_addr=0, fb_data=0. An in-flight sprite is abandoned. No write occurs after reset asserts.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 at a posedge latches pos_x, pos_y and rom_base.
  - Clears sx, sy and the linear pixel counter pix.
  - Moves to RUN.
  - start in any other state is ignored; no queueing.
- RUN:
  - rom_address = rom_base + pix (ROM_AW bits, wraps modulo 2^ROM_AW). pix is a plain counter; no multiply is used on the ROM side.
  - Each posedge: pix+1 and sx+1; when sx = SPRITE_W-1, sx goes to 0 and sy+1.
  - Stage 1 registers, captured each RUN posedge:
    - stage_valid = 1.
    - stage_inb = (pos_x+sx < FB_W) && (pos_y+sy < FB_H), computed at 11 bits so there is no overflow.
    - stage_addr = (pos_y+sy)*FB_W + (pos_x+sx), truncated to FB_AW.
  - Moves to DRAIN at the posedge that issues the last pixel (pix = SPRITE_W*SPRITE_H-1).
- DRAIN: completes the last write; stage_valid is cleared at exit; moves to DONE.
- DONE: done=1 for exactly one cycle; then IDLE. A new start is accepted in the IDLE cycle that follows.
- Write port (combinational from stage registers and rom_q):
  - fb_we = stage_valid && stage_inb && (rom_q != TRANSP_IDX).
  - fb_addr = stage_addr; fb_data = rom_q.
- Timing, with start sampled at posedge 0 and N = SPRITE_W*SPRITE_H:
  - RUN occupies cycles 1..N.
  - Writes occur in cycles 2..N+1; DRAIN is cycle N+1.
  - done is high in cycle N+2.
  - busy is high in cycles 1..N+1.
  - Throughput: 1 pixel per cycle.
- Clipping: off-screen pixels still consume a cycle (fixed latency) but produce no write. Fully off-screen sprites complete normally with zero writes.
- busy = (state==RUN || state==DRAIN); done = (state==DONE).

Decomposition:
- Shared package sprite_pkg:
  - blit_state_t enum (IDLE, RUN, DRAIN, DONE).
  - PALETTE_IDX_W = 4.
  - FB_W and FB_H defaults.
  - TRANSP_IDX default.
- Sub-module: none required. Optionally, blit_addr_gen (sx/sy/pix counters plus clip/address stage) if the write path is split out.

Test Plan:
- SPRITE_W=4, SPRITE_H=2, ROM pattern 1..8, pos=(10,20), rom_base=0, start pulse:
  - 8 writes, fb_addr = 20*320+10..13 and 21*320+10..13, fb_data = 1..8.
  - busy for 9 cycles; done in cycle 10.
- Same sprite with ROM words 2 and 5 = TRANSP_IDX: exactly 6 writes; addresses for pixels 2 and 5 are never written; done timing unchanged.
- pos=(318,239): only pixels (sx 0..1, sy 0) write, at addresses 239*320+318 and 239*320+319; the other 6 are suppressed; done still in cycle 10.
- pos=(400,300), fully off-screen: zero fb_we; busy 9 cycles; done pulse delivered.
- start held high across the whole draw, with changing pos_x while busy: only one draw, using the originally latched values; a second draw starts the cycle after IDLE is re-entered.
- reset asserted mid-RUN at pixel 3:
  - Immediately busy=0, fb_we=0, done=0, and no further writes.
  - After release, a new start completes a full 8-pixel draw.
